qed_dup_sequencer: RTL and testbench
====================================

# qed_dup_sequencer

Sequential QED (Quick Error Detection) duplication stage between instruction fetch and decode. In QED mode it passes original instructions through unmodified while buffering the duplicable ones in a DEPTH-entry FIFO. It then drains the FIFO as duplicates re-targeted to the shadow register half (x16–x31) and the shadow memory region. It tracks original/duplicate counts and raises `qed_ready` when both streams are balanced, so the formal checker can compare register halves.

## Interface
- `DEPTH`, 8, FIFO entries; power of 2, ≥2.
- `CNT_W`, 8, width of orig/dup counters; must satisfy 2^CNT_W > DEPTH+1.
- `clk` input 1 — single clock, all state on rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `qed_ena` input 1 — enable QED duplication; 0 = pure pass-through.
- `dup_req` input 1 — request early switch to DUP phase (single-cycle pulse).
- `in_valid` input 1 — fetch instruction valid.
- `in_ready` output 1 — stage accepts instruction this cycle.
- `in_instr` input 32 — RV32 instruction.
- `out_valid` output 1 — output register holds an instruction.
- `out_ready` input 1 — decode accepts output.
- `out_instr` output 32 — original or duplicate instruction.
- `out_is_dup` output 1 — out_instr is a duplicate.
- `qed_ready` output 1 — orig_cnt == dup_cnt.

## Operation
- Classification (opcode [6:0], funct3 [14:12]): LW = 0000011/010; SW = 0100011/010; ALUIMM = 0010011; ALUREG = 0110011 (includes M-extension). Only these four classes are duplicable. All other instructions pass through, are never buffered, and are not counted.
- Register remap r': r==0 → 0, else {1'b1, r[3:0]}.
- Duplicate forms (fields per RV32 encoding):
  - LW: imm = {2'b01, imm[9:0]}, rs1 = x0, rd = rd'.
  - SW: imm[11:5] = {2'b01, imm[9:5]}, imm[4:0] unchanged, rs1 = x0, rs2 = rs2'.
  - ALUIMM: imm/funct3 unchanged, rs1', rd'.
  - ALUREG: funct7/funct3 unchanged, rs1', rs2', rd'.
- FSM states: ORIG, DUP.
- ORIG:
  - in_ready = !rst && !fifo_full && (!out_valid || out_ready).
  - On accept: out_instr = in_instr, out_is_dup = 0.
  - If qed_ena and duplicable: push in_instr into the FIFO and increment orig_cnt.
  - Go to DUP at end of cycle if any of the following hold:
    - FIFO count == DEPTH after this cycle's push;
    - dup_req=1 and FIFO non-empty (counting this cycle's push);
    - qed_ena=0 and FIFO non-empty (flush).
- DUP:
  - in_ready = 0.
  - When the output slot is free (!out_valid || out_ready): pop FIFO head, load its duplicate form, set out_is_dup = 1.
  - Return to ORIG on the cycle the last entry is popped.
  - dup_req and qed_ena are ignored; the drain always completes.
- dup_cnt increments on the output handshake (out_valid && out_ready) of a duplicate.
- Counters wrap modulo 2^CNT_W; the equality check remains valid because the difference is always ≤ DEPTH+1.
- FIFO: circular buffer with pointers wrapping at DEPTH. In ORIG, push and pop never occur in the same cycle.

## Timing
- Reset values: state ORIG, FIFO empty, orig_cnt = dup_cnt = 0, out_valid = 0, out_instr = 0, out_is_dup = 0. Hence qed_ready = 1 and in_ready = 0 while rst=1.
- Latency: input accept → out_valid in the next cycle.
- Throughput: 1 instruction/cycle with out_ready=1, in both ORIG and DUP.
- ORIG→DUP costs no bubble: the first duplicate is loaded on the first DUP cycle.
- Backpressure: while out_valid && !out_ready, out_instr and out_is_dup hold stable and no pop or accept occurs.
- qed_ready is combinational from the counters. It updates the cycle after the final duplicate handshake.
- rst asserted mid-DUP: the FIFO and in-flight output are discarded and all state returns to reset values next cycle.

## Test plan
- qed_ena=1, DEPTH=8, out_ready=1, send lw x5,8(x3) = 0x0081A283, then pulse dup_req → out 0x0081A283 (dup=0), then 0x40802A83 (dup=1); qed_ready goes 1→0→1.
- add x1,x2,x3 = 0x003100B3 with dup_req → duplicate 0x013908B3. addi x0,x0,0 = 0x00000013 → duplicate 0x00000013 (x0 preserved).
- DEPTH=4, stream 4 addi back to back, no dup_req → auto DUP; in_ready low for exactly 4 cycles; 4 duplicates in FIFO order; qed_ready=1 the cycle after the 4th handshake.
- Stream JAL (0x0000006F) while qed_ena=1 → passes through, not buffered, qed_ready stays 1.
- Hold out_ready=0 for 3 cycles in DUP → out_instr stable, FIFO count unchanged; release → drain resumes one per cycle.
- Assert rst with 3 entries buffered in DUP → next cycle out_valid=0, qed_ready=1, in_ready=1, state ORIG.

Source files
------------

// File: rtl/qed_dup_sequencer.sv
// -----------------------------------------------------------------------------
// qed_dup_sequencer
//
// Sequential QED duplication stage between instruction fetch and decode.
// In the ORIG phase, instructions pass straight through to a single output
// register. In QED mode, duplicable instructions (LW, SW, ALU-imm, ALU-reg)
// are also queued in a DEPTH-entry FIFO. In the DUP phase the FIFO drains as
// duplicates re-targeted to the shadow register half (x16-x31) and the shadow
// memory region. Original and duplicate counters drive qed_ready, which goes
// high when the two streams are balanced.
//
// Parameters
//   DEPTH      FIFO entries (power of 2, >= 2)
//   CNT_W      width of the orig/dup counters (2**CNT_W > DEPTH+1)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   qed_ena    enable duplication (0 = pure pass-through, flushes FIFO)
//   dup_req    single-cycle request to start draining early
//   in_valid   fetch instruction valid
//   in_ready   stage accepts an instruction this cycle
//   in_instr   RV32 instruction from fetch
//   out_valid  output register holds an instruction
//   out_ready  decode accepts the output
//   out_instr  original or duplicate instruction
//   out_is_dup out_instr is a duplicate
//   qed_ready  original count equals duplicate count
// -----------------------------------------------------------------------------
module qed_dup_sequencer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        qed_ena,
  input  logic        dup_req,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_is_dup,
  output logic        qed_ready
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FCNT_W = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [2:0] F3_WORD   = 3'b010;

  typedef enum logic {
    ST_ORIG = 1'b0,
    ST_DUP  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Instruction classification and duplicate construction
  // ---------------------------------------------------------------------------

  // x0 stays x0; every other register maps into the shadow half x16-x31.
  function automatic logic [4:0] remap(input logic [4:0] r);
    remap = (r == 5'd0) ? 5'd0 : {1'b1, r[3:0]};
  endfunction

  function automatic logic is_dupable(input logic [31:0] i);
    logic [6:0] op;
    logic [2:0] f3;
    op = i[6:0];
    f3 = i[14:12];
    is_dupable = ((op == OP_LOAD)  && (f3 == F3_WORD)) ||
                 ((op == OP_STORE) && (f3 == F3_WORD)) ||
                 (op == OP_ALUIMM) ||
                 (op == OP_ALUREG);
  endfunction

  // Memory duplicates use rs1 = x0 with bit 10 of the offset forced high, so
  // they address the shadow window instead of the original base register.
  function automatic logic [31:0] dup_form(input logic [31:0] i);
    logic [31:0] d;
    d = i;
    case (i[6:0])
      OP_LOAD:   d = {2'b01, i[29:20], 5'd0, i[14:12], remap(i[11:7]), i[6:0]};
      OP_STORE:  d = {2'b01, i[29:25], remap(i[24:20]), 5'd0, i[14:12],
                      i[11:7], i[6:0]};
      OP_ALUIMM: d = {i[31:20], remap(i[19:15]), i[14:12], remap(i[11:7]),
                      i[6:0]};
      OP_ALUREG: d = {i[31:25], remap(i[24:20]), remap(i[19:15]), i[14:12],
                      remap(i[11:7]), i[6:0]};
      default:   d = i;
    endcase
    dup_form = d;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state;
  logic [31:0]        fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [FCNT_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]   orig_cnt;
  logic [CNT_W-1:0]   dup_cnt;

  // ---------------------------------------------------------------------------
  // Handshake and control decode
  // ---------------------------------------------------------------------------
  logic              slot_free;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              push;
  logic              pop;
  logic              out_fire;
  logic [FCNT_W-1:0] cnt_after_push;
  logic              go_dup;

  always_comb begin
    slot_free      = !out_valid || out_ready;
    fifo_full      = (fifo_cnt == FCNT_W'(DEPTH));
    fifo_empty     = (fifo_cnt == '0);
    in_ready       = !rst && (state == ST_ORIG) && !fifo_full && slot_free;
    accept         = in_valid && in_ready;
    push           = accept && qed_ena && is_dupable(in_instr);
    pop            = (state == ST_DUP) && slot_free && !fifo_empty;
    out_fire       = out_valid && out_ready;
    cnt_after_push = fifo_cnt + FCNT_W'(push);
    // All switch conditions look at the occupancy including this cycle's push,
    // so the instruction being accepted is part of the drain that follows.
    go_dup         = (cnt_after_push == FCNT_W'(DEPTH)) ||
                     ((dup_req || !qed_ena) && (cnt_after_push != '0));
    qed_ready      = (orig_cnt == dup_cnt);
  end

  // ---------------------------------------------------------------------------
  // FIFO storage (holds ready-made duplicate forms; no reset needed)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= dup_form(in_instr);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM, pointers, counters and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ORIG;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      orig_cnt   <= '0;
      dup_cnt    <= '0;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_is_dup <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        orig_cnt <= orig_cnt + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      // Push happens only in ORIG and pop only in DUP, so they never coincide.
      if (push) begin
        fifo_cnt <= fifo_cnt + FCNT_W'(1);
      end else if (pop) begin
        fifo_cnt <= fifo_cnt - FCNT_W'(1);
      end

      if (out_fire && out_is_dup) begin
        dup_cnt <= dup_cnt + CNT_W'(1);
      end

      if (accept) begin
        out_valid  <= 1'b1;
        out_instr  <= in_instr;
        out_is_dup <= 1'b0;
      end else if (pop) begin
        out_valid  <= 1'b1;
        out_instr  <= fifo_mem[rd_ptr];
        out_is_dup <= 1'b1;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end

      case (state)
        ST_ORIG: begin
          if (go_dup) begin
            state <= ST_DUP;
          end
        end
        ST_DUP: begin
          if (pop && (fifo_cnt == FCNT_W'(1))) begin
            state <= ST_ORIG;
          end
        end
        default: state <= ST_ORIG;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_no_push_pop: assert property (@(posedge clk) disable iff (rst)
    !(push && pop));

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    fifo_cnt <= FCNT_W'(DEPTH));

  a_no_push_in_dup: assert property (@(posedge clk) disable iff (rst)
    (state == ST_DUP) |-> !accept);

  a_dup_not_empty: assert property (@(posedge clk) disable iff (rst)
    (state == ST_DUP) |-> !fifo_empty);

  a_balance: assert property (@(posedge clk) disable iff (rst)
    (CNT_W'(orig_cnt - dup_cnt) <= CNT_W'(DEPTH + 1)));

  a_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(out_instr) && $stable(out_is_dup)));

endmodule

// File: tb/tb_qed_dup_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_qed_dup_sequencer
//
// Two instances: index 0 with DEPTH=8, index 1 with DEPTH=4. Stimulus pushes
// hand-computed expected outputs into a per-instance scoreboard queue; a
// monitor pops and compares on every output handshake. Duplicates are parked
// in a pending queue until the stimulus causes a drain (dup_req, full FIFO or
// qed_ena drop), which keeps the expected order originals-then-duplicates.
// -----------------------------------------------------------------------------
module tb_qed_dup_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rs   [2];
  logic        qe   [2];
  logic        dr   [2];
  logic        iv   [2];
  logic        ordy [2];
  logic [31:0] ii   [2];
  logic        ir   [2];
  logic        ov   [2];
  logic        od   [2];
  logic        qr   [2];
  logic [31:0] oi   [2];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [32:0] exp0[$];
  logic [32:0] exp1[$];
  logic [32:0] pend0[$];
  logic [32:0] pend1[$];

  qed_dup_sequencer #(.DEPTH(8), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rs[0]), .qed_ena(qe[0]), .dup_req(dr[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_instr(ii[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_instr(oi[0]),
    .out_is_dup(od[0]), .qed_ready(qr[0])
  );

  qed_dup_sequencer #(.DEPTH(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst(rs[1]), .qed_ena(qe[1]), .dup_req(dr[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_instr(ii[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_instr(oi[1]),
    .out_is_dup(od[1]), .qed_ready(qr[1])
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_size(input int s);
    return (s == 0) ? exp0.size() : exp1.size();
  endfunction

  task automatic transfer(input int s);
    if (s == 0) begin
      while (pend0.size() > 0) exp0.push_back(pend0.pop_front());
    end else begin
      while (pend1.size() > 0) exp1.push_back(pend1.pop_front());
    end
  endtask

  // Present one instruction and hold it until accepted (bounded).
  task automatic send(input int s, input logic [31:0] ins, input logic dupl,
                      input logic [31:0] dupv);
    int unsigned waited;
    waited = 0;
    iv[s] = 1'b1;
    ii[s] = ins;
    #1;
    while (!ir[s] && waited < 50) begin
      step();
      waited++;
    end
    check($sformatf("accept%0d_%08h", s, ins), 64'(ir[s]), 64'd1);
    if (!ir[s]) begin
      iv[s] = 1'b0;
      return;
    end
    if (s == 0) exp0.push_back({1'b0, ins});
    else        exp1.push_back({1'b0, ins});
    if (dupl) begin
      if (s == 0) begin
        pend0.push_back({1'b1, dupv});
        if (pend0.size() == 8) transfer(0);
      end else begin
        pend1.push_back({1'b1, dupv});
        if (pend1.size() == 4) transfer(1);
      end
    end
    step();
    iv[s] = 1'b0;
  endtask

  task automatic dup_pulse(input int s);
    dr[s] = 1'b1;
    transfer(s);
    step();
    dr[s] = 1'b0;
  endtask

  task automatic wait_idle(input int s, input string name);
    for (int i = 0; i < 100; i++) begin
      if (exp_size(s) == 0) break;
      step();
    end
    check({name, "_drained"}, 64'(exp_size(s)), 64'd0);
  endtask

  // Scoreboard monitor
  task automatic mon(input int s, input logic [31:0] instr, input logic isdup);
    logic [32:0] e;
    if (exp_size(s) == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_out%0d: got dup=%0b instr=0x%08h, expected no output",
               s, isdup, instr);
    end else begin
      if (s == 0) e = exp0.pop_front();
      else        e = exp1.pop_front();
      check($sformatf("out%0d", s), 64'({isdup, instr}), 64'(e));
    end
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (!rs[s] && ov[s] && ordy[s]) mon(s, oi[s], od[s]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned low;
    for (int s = 0; s < 2; s++) begin
      rs[s] = 1'b1; qe[s] = 1'b1; dr[s] = 1'b0;
      iv[s] = 1'b0; ordy[s] = 1'b1; ii[s] = '0;
    end
    repeat (3) step();

    // Reset state
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst_in_ready%0d", s),   64'(ir[s]), 64'd0);
      check($sformatf("rst_qed_ready%0d", s),  64'(qr[s]), 64'd1);
      check($sformatf("rst_out_valid%0d", s),  64'(ov[s]), 64'd0);
      check($sformatf("rst_out_instr%0d", s),  64'(oi[s]), 64'd0);
      check($sformatf("rst_out_is_dup%0d", s), 64'(od[s]), 64'd0);
    end
    rs[0] = 1'b0;
    rs[1] = 1'b0;
    #1;
    check("post_rst_in_ready0", 64'(ir[0]), 64'd1);
    check("post_rst_in_ready1", 64'(ir[1]), 64'd1);

    // lw x5,8(x3) then dup_req; qed_ready 1 -> 0 -> 1
    check("lw_qed_ready_pre", 64'(qr[0]), 64'd1);
    send(0, 32'h0081A283, 1'b1, 32'h40802A83);
    check("lw_qed_ready_mid", 64'(qr[0]), 64'd0);
    dup_pulse(0);
    wait_idle(0, "lw");
    check("lw_qed_ready_post", 64'(qr[0]), 64'd1);

    // add, addi x0 (x0 preserved), sw x6,12(x7)
    send(0, 32'h003100B3, 1'b1, 32'h013908B3);
    send(0, 32'h00000013, 1'b1, 32'h00000013);
    send(0, 32'h0063A623, 1'b1, 32'h41602623);
    check("mix_qed_ready_mid", 64'(qr[0]), 64'd0);
    dup_pulse(0);
    wait_idle(0, "mix");
    check("mix_qed_ready_post", 64'(qr[0]), 64'd1);

    // JAL is not duplicable: passes through, no DUP phase
    send(0, 32'h0000006F, 1'b0, 32'h0);
    check("jal_qed_ready", 64'(qr[0]), 64'd1);
    step();
    check("jal_in_ready", 64'(ir[0]), 64'd1);
    wait_idle(0, "jal");

    // Dropping qed_ena flushes buffered entries
    send(0, 32'h00108093, 1'b1, 32'h00188893);
    qe[0] = 1'b0;
    transfer(0);
    wait_idle(0, "flush");
    check("flush_qed_ready", 64'(qr[0]), 64'd1);
    // Pure pass-through while disabled
    send(0, 32'h0081A283, 1'b0, 32'h0);
    wait_idle(0, "passthru");
    check("passthru_qed_ready", 64'(qr[0]), 64'd1);
    qe[0] = 1'b1;

    // DEPTH=4: four addi back to back fill the FIFO and force DUP
    send(1, 32'h00100093, 1'b1, 32'h00100893);
    send(1, 32'h00200113, 1'b1, 32'h00200913);
    send(1, 32'h00300193, 1'b1, 32'h00300993);
    send(1, 32'h00400213, 1'b1, 32'h00400A13);
    low = 0;
    while (!ir[1] && low < 20) begin
      low++;
      step();
    end
    check("full_in_ready_low_cycles", 64'(low), 64'd4);
    check("full_qed_ready_before_last", 64'(qr[1]), 64'd0);
    step();
    check("full_qed_ready_after_last", 64'(qr[1]), 64'd1);
    wait_idle(1, "full");

    // Backpressure in DUP
    send(1, 32'h00730293, 1'b1, 32'h007B0A93);
    send(1, 32'h00A4E433, 1'b1, 32'h01ACEC33);
    send(1, 32'hFFC12783, 1'b1, 32'h7FC02F83);
    dup_pulse(1);
    ordy[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("bp_valid_c%0d", c),  64'(ov[1]), 64'd1);
      check($sformatf("bp_instr_c%0d", c),  64'(oi[1]), 64'h007B0A93);
      check($sformatf("bp_is_dup_c%0d", c), 64'(od[1]), 64'd1);
    end
    ordy[1] = 1'b1;
    step();
    check("bp_resume_1", 64'(oi[1]), 64'h01ACEC33);
    step();
    check("bp_resume_2", 64'(oi[1]), 64'h7FC02F83);
    step();
    check("bp_done_valid", 64'(ov[1]), 64'd0);
    check("bp_qed_ready", 64'(qr[1]), 64'd1);
    wait_idle(1, "bp");

    // Reset asserted mid-DUP with three entries buffered
    send(1, 32'h00100093, 1'b1, 32'h00100893);
    send(1, 32'h00200113, 1'b1, 32'h00200913);
    send(1, 32'h00300193, 1'b1, 32'h00300993);
    dup_pulse(1);
    rs[1] = 1'b1;
    exp1.delete();
    pend1.delete();
    step();
    rs[1] = 1'b0;
    #1;
    check("midrst_out_valid", 64'(ov[1]), 64'd0);
    check("midrst_qed_ready", 64'(qr[1]), 64'd1);
    check("midrst_in_ready",  64'(ir[1]), 64'd1);
    repeat (4) step();
    check("midrst_quiet_valid", 64'(ov[1]), 64'd0);

    check("end_exp0_empty",  64'(exp0.size()),  64'd0);
    check("end_exp1_empty",  64'(exp1.size()),  64'd0);
    check("end_pend0_empty", 64'(pend0.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
